// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared types, state encoding and gain clamp for the EQ gain sequencer
package eq_pkg;

  localparam int DEFAULT_NUM_BANDS = 10;
  localparam int GAIN_W = 16;

  typedef logic signed [GAIN_W-1:0] gain_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO
  } seq_state_t;

  function automatic gain_t gain_clamp(input int value, input int limit);
    if (value > limit) return gain_t'(limit);
    if (value < -limit) return gain_t'(-limit);
    return gain_t'(value);
  endfunction

endpackage

// File: rtl/eq_gain_sequencer_if.sv
// rtl/eq_gain_sequencer_if.sv - front-panel edit, biquad set/busy and readback signals
interface eq_gain_sequencer_if #(
  parameter int NB = eq_pkg::DEFAULT_NUM_BANDS
);
  import eq_pkg::*;

  localparam int BW = $clog2(NB);

  logic [BW-1:0] i_band;
  logic          i_up;
  logic          i_down;
  logic          i_flat;
  logic [NB-1:0] i_busy;
  logic [NB-1:0] o_set;
  gain_t         o_gain;
  logic [BW-1:0] i_rd_band;
  gain_t         o_rd_gain;
  logic          o_idle;

  modport master (
    output i_band, i_up, i_down, i_flat, i_busy, i_rd_band,
    input  o_set, o_gain, o_rd_gain, o_idle
  );

  modport slave (
    input  i_band, i_up, i_down, i_flat, i_busy, i_rd_band,
    output o_set, o_gain, o_rd_gain, o_idle
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first request after i_last, wrapping
module rr_picker #(
  parameter int N  = 10,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic          o_valid
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0] idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = {1'b0, i_last} + (IW+1)'(k);
      if (idx >= N_W) idx = idx - N_W;
      if (!o_valid && i_req[idx[IW-1:0]]) begin
        o_grant[idx[IW-1:0]] = 1'b1;
        o_valid              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eq_gain_sequencer.sv
// rtl/eq_gain_sequencer.sv - per-band gain registers pushed one band at a time to the biquad bank
module eq_gain_sequencer
  import eq_pkg::*;
#(
  parameter int NUM_BANDS   = DEFAULT_NUM_BANDS,
  parameter int GAIN_MAX    = 12,
  parameter int GAIN_STEP   = 1,
  parameter int SET_TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  eq_gain_sequencer_if.slave   bus
);

  localparam int BW = $clog2(NUM_BANDS);
  localparam int TW = $clog2(SET_TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BAND = BW'(NUM_BANDS - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(SET_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);

  seq_state_t           state_q, state_d;
  gain_t                gain_q [NUM_BANDS];
  gain_t                gain_d [NUM_BANDS];
  logic [NUM_BANDS-1:0] dirty_q, dirty_d;
  logic [BW-1:0]        band_q, band_d;
  gain_t                out_gain_q, out_gain_d;
  logic [TW-1:0]        timer_q, timer_d;
  gain_t                rd_gain_q, rd_gain_d;
  logic                 idle_q, idle_d;

  logic [NUM_BANDS-1:0] pick_grant;
  logic                 pick_valid;
  logic [BW-1:0]        pick_idx;
  logic                 edit_ok;
  gain_t                edit_gain;
  logic [TW-1:0]        timer_inc;
  logic [NUM_BANDS-1:0] set_vec;

  rr_picker #(.N(NUM_BANDS), .IW(BW)) u_picker (
    .i_req   (dirty_q),
    .i_last  (band_q),
    .o_grant (pick_grant),
    .o_valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (pick_grant[i]) pick_idx = BW'(i);
    end
  end

  // Edits run every cycle regardless of the FSM; an edit landing on the band
  // being picked re-arms its dirty bit, so the newer value is sent afterwards.
  always_comb begin
    edit_ok   = (bus.i_band <= LAST_BAND) && (bus.i_up ^ bus.i_down);
    edit_gain = gain_clamp(int'(gain_q[bus.i_band]) + (bus.i_up ? GAIN_STEP : -GAIN_STEP),
                           GAIN_MAX);
    gain_d    = gain_q;
    dirty_d   = dirty_q;
    if (state_q == S_IDLE && pick_valid) dirty_d = dirty_q & ~pick_grant;
    if (bus.i_flat) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        if (gain_q[i] != '0) begin
          gain_d[i]  = '0;
          dirty_d[i] = 1'b1;
        end
      end
    end else if (edit_ok && edit_gain != gain_q[bus.i_band]) begin
      gain_d[bus.i_band]  = edit_gain;
      dirty_d[bus.i_band] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    band_d     = band_q;
    out_gain_d = out_gain_q;
    timer_d    = timer_q;
    timer_inc  = (timer_q == '1) ? timer_q : timer_q + T_ONE;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          band_d     = pick_idx;
          out_gain_d = gain_q[pick_idx];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.i_busy[band_q]) begin
          timer_d = '0;
          state_d = S_WAIT_LO;
        end else if (timer_q >= T_LAST) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT_LO: begin
        if (!bus.i_busy[band_q] || timer_q >= T_LAST) state_d = S_IDLE;
        else timer_d = timer_inc;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    set_vec = '0;
    if (state_q == S_ISSUE) set_vec[band_q] = 1'b1;
    rd_gain_d = (bus.i_rd_band <= LAST_BAND) ? gain_q[bus.i_rd_band] : '0;
    idle_d    = (state_q == S_IDLE) && (dirty_q == '0);
  end

  // Dirty starts all-ones so every biquad is loaded once after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_BANDS; i++) gain_q[i] <= '0;
      dirty_q    <= '1;
      band_q     <= LAST_BAND;
      out_gain_q <= '0;
      timer_q    <= '0;
      rd_gain_q  <= '0;
      idle_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      dirty_q    <= dirty_d;
      band_q     <= band_d;
      out_gain_q <= out_gain_d;
      timer_q    <= timer_d;
      rd_gain_q  <= rd_gain_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.o_set     = set_vec;
  assign bus.o_gain    = out_gain_q;
  assign bus.o_rd_gain = rd_gain_q;
  assign bus.o_idle    = idle_q;

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// tb/tb_eq_gain_sequencer.sv - directed and randomized checks of eq_gain_sequencer against a gain model
module tb_eq_gain_sequencer;
  import eq_pkg::*;

  localparam int NB   = 10;
  localparam int BW   = $clog2(NB);
  localparam int GMAX = 12;
  localparam int TMO  = 64;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  eq_gain_sequencer_if #(.NB(NB)) bus ();

  eq_gain_sequencer #(
    .NUM_BANDS(NB), .GAIN_MAX(GMAX), .GAIN_STEP(1), .SET_TIMEOUT(TMO)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mgain     [NB];
  int last_sent [NB];
  int busy_w    [NB];
  int busy_cnt  [NB];
  logic [NB-1:0] stuck;
  logic [NB-1:0] busy_v;
  int sent_band [$];
  int sent_gain [$];
  int sent_cyc  [$];
  int multi_hot = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always_comb begin
    busy_v = '0;
    for (int b = 0; b < NB; b++) busy_v[b] = (busy_cnt[b] > 0);
  end
  assign bus.i_busy = busy_v;

  // Biquad stand-in: each set strobe raises that band's busy for busy_w cycles.
  always @(negedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_rst) busy_cnt[b] <= 0;
      else if (bus.o_set[b] && !stuck[b]) busy_cnt[b] <= busy_w[b];
      else if (busy_cnt[b] > 0) busy_cnt[b] <= busy_cnt[b] - 1;
    end
    if (!i_rst && bus.o_set != '0) begin
      if ($countones(bus.o_set) != 1) multi_hot <= multi_hot + 1;
      for (int b = 0; b < NB; b++) begin
        if (bus.o_set[b]) begin
          sent_band.push_back(b);
          sent_gain.push_back(int'(bus.o_gain));
          sent_cyc.push_back(cyc);
          last_sent[b] <= int'(bus.o_gain);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v > GMAX) return GMAX;
    if (v < -GMAX) return -GMAX;
    return v;
  endfunction

  task automatic edit(input int band, input bit up, input bit down);
    bus.i_band = BW'(band);
    bus.i_up   = up;
    bus.i_down = down;
    tick();
    bus.i_up   = 1'b0;
    bus.i_down = 1'b0;
    if (band < NB && up != down) mgain[band] = clampi(mgain[band] + (up ? 1 : -1));
  endtask

  task automatic flat();
    bus.i_flat = 1'b1;
    tick();
    bus.i_flat = 1'b0;
    for (int b = 0; b < NB; b++) mgain[b] = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    tick();
    tick();
    while (bus.o_idle !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, bus.o_idle, 1);
  endtask

  task automatic clear_log();
    sent_band.delete();
    sent_gain.delete();
    sent_cyc.delete();
  endtask

  task automatic wait_sent(input string tag, input int budget);
    int n;
    n = 0;
    while (sent_band.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, sent_band.size(), 1);
  endtask

  initial begin
    int e;
    i_rst         = 1'b1;
    bus.i_band    = '0;
    bus.i_up      = 1'b0;
    bus.i_down    = 1'b0;
    bus.i_flat    = 1'b0;
    bus.i_rd_band = '0;
    stuck         = '0;
    for (int b = 0; b < NB; b++) begin
      mgain[b]     = 0;
      busy_w[b]    = 3;
      last_sent[b] = -99;
    end
    repeat (3) tick();
    check("reset o_set", bus.o_set, 0);
    check("reset o_gain", bus.o_gain, 0);
    check("reset o_rd_gain", bus.o_rd_gain, 0);
    check("reset o_idle", bus.o_idle, 0);

    // 1: every band loaded once, in order, after reset release
    i_rst = 1'b0;
    wait_idle("t1 idle", 150);
    check("t1 count", sent_band.size(), NB);
    for (int b = 0; b < NB && b < sent_band.size(); b++) begin
      check("t1 order", sent_band[b], b);
      check("t1 gain", sent_gain[b], 0);
    end
    if (sent_cyc.size() >= 2) check("t1 spacing", sent_cyc[1] - sent_cyc[0], 5);
    clear_log();

    // 2: saturation at +12 and set latency of two cycles from an idle edit
    e = cyc;
    edit(3, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      edit(3, 1'b1, 1'b0);
    end
    wait_idle("t2 idle", 200);
    if (sent_cyc.size() >= 1) begin
      check("t2 latency", sent_cyc[0] - e, 2);
      check("t2 first gain", sent_gain[0], 1);
    end
    for (int i = 0; i < sent_band.size(); i++) check("t2 band", sent_band[i], 3);
    check("t2 last sent", last_sent[3], 12);
    bus.i_rd_band = BW'(3);
    tick();
    check("t2 readback", bus.o_rd_gain, 12);
    bus.i_rd_band = BW'(13);
    tick();
    check("t2 readback oob", bus.o_rd_gain, 0);
    clear_log();

    // 3: up+down together and out-of-range band are dropped
    edit(5, 1'b1, 1'b1);
    edit(11, 1'b1, 1'b0);
    repeat (8) tick();
    check("t3 no set", sent_band.size(), 0);
    check("t3 idle", bus.o_idle, 1);
    bus.i_rd_band = BW'(5);
    tick();
    check("t3 readback", bus.o_rd_gain, 0);

    // 4: edits during a long busy leave o_gain alone and cause one re-send
    busy_w[2] = 20;
    edit(2, 1'b1, 1'b0);
    wait_sent("t4 first set", 20);
    edit(2, 1'b1, 1'b0);
    edit(2, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("t4 hold", bus.o_gain, 1);
      tick();
    end
    wait_idle("t4 idle", 200);
    check("t4 count", sent_band.size(), 2);
    if (sent_band.size() >= 2) begin
      check("t4 resend band", sent_band[1], 2);
      check("t4 resend gain", sent_gain[1], mgain[2]);
    end
    busy_w[2] = 3;
    clear_log();

    // 5: band 7 never raises busy; abandoned, then band 8 served
    stuck[7] = 1'b1;
    edit(7, 1'b1, 1'b0);
    edit(8, 1'b1, 1'b0);
    wait_idle("t5 idle", 300);
    check("t5 count", sent_band.size(), 2);
    if (sent_band.size() >= 2) begin
      check("t5 first", sent_band[0], 7);
      check("t5 second", sent_band[1], 8);
      check("t5 gap", sent_cyc[1] - sent_cyc[0], TMO + 2);
    end
    stuck[7] = 1'b0;
    clear_log();

    // random edits, flats and busy widths against the gain model
    for (int b = 0; b < NB; b++) busy_w[b] = $urandom_range(2, 5);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) flat();
      else edit($urandom_range(0, 11), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle("rand idle", 800);
    for (int b = 0; b < NB; b++) begin
      check("rand last sent", last_sent[b], mgain[b]);
      bus.i_rd_band = BW'(b);
      tick();
      check("rand readback", bus.o_rd_gain, mgain[b]);
    end
    for (int b = 0; b < NB; b++) busy_w[b] = 3;

    // 6: flat re-sends only the nonzero bands
    flat();
    wait_idle("t6 idle a", 300);
    edit(0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) edit(1, 1'b0, 1'b1);
    wait_idle("t6 idle b", 200);
    check("t6 band1", last_sent[1], -4);
    clear_log();
    flat();
    wait_idle("t6 idle c", 200);
    check("t6 count", sent_band.size(), 2);
    if (sent_band.size() >= 2) begin
      check("t6 band a", sent_band[0], 0);
      check("t6 band b", sent_band[1], 1);
      check("t6 gain a", sent_gain[0], 0);
      check("t6 gain b", sent_gain[1], 0);
    end
    clear_log();

    // reset in the middle of a transaction
    busy_w[4] = 20;
    edit(4, 1'b1, 1'b0);
    wait_sent("t6 rst set", 20);
    repeat (3) tick();
    check("t6 gain before rst", bus.o_gain, 1);
    i_rst = 1'b1;
    tick();
    check("t6 rst o_set", bus.o_set, 0);
    check("t6 rst o_gain", bus.o_gain, 0);
    check("t6 rst o_idle", bus.o_idle, 0);
    check("t6 rst o_rd_gain", bus.o_rd_gain, 0);
    for (int b = 0; b < NB; b++) mgain[b] = 0;
    busy_w[4] = 3;
    tick();
    clear_log();
    i_rst = 1'b0;
    wait_idle("t6 post rst idle", 150);
    check("t6 post rst count", sent_band.size(), NB);
    for (int b = 0; b < NB; b++) check("t6 post rst gain", last_sent[b], mgain[b]);

    check("one-hot set", multi_hot, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
